// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte-wide memory responder with RAM and UART TX/RX FIFO window
module ram_io_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH       = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_THRESH = CW'(FIFO_DEPTH - FULL_MARGIN);

    // Address decode: bits 17:16 == 11 select the IO window, everything else is RAM.
    logic                  is_io;
    logic                  sel_data;
    logic                  sel_stat;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  unused_addr_bits;

    assign is_io            = (mem_a[17:16] == 2'b11);
    assign sel_data         = is_io && (mem_a[15:0] == 16'h0000);
    assign sel_stat         = is_io && (mem_a[15:0] == 16'h0004);
    assign ram_addr         = mem_a[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^mem_a[31:18];

    logic [7:0] ram [2**ADDR_WIDTH];

    // TX FIFO state
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wr_ptr;
    logic [PW-1:0] tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] tx_count_next;
    logic          tx_push;
    logic          tx_pop;

    // RX FIFO state
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wr_ptr;
    logic [PW-1:0] rx_rd_ptr;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] rx_count_next;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_nonempty;

    logic [7:0]    rd_data;

    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
    assign tx_pop   = tx_valid && tx_ready;
    // A pop at full frees the slot being written, so the push is still accepted.
    assign tx_push  = mem_wr && sel_data && ((tx_count != DEPTH) || tx_pop);

    assign rx_nonempty = (rx_count != '0);
    assign rx_push     = rx_valid && rx_ready;
    // An empty FIFO is never popped, even if a byte arrives in the same cycle.
    assign rx_pop      = !mem_wr && sel_data && rx_nonempty;

    // Next occupancy for both FIFOs; feeds the count registers and the flag registers.
    always_comb begin
        tx_count_next = tx_count;
        rx_count_next = rx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + CW'(1);
            2'b01:   tx_count_next = tx_count - CW'(1);
            default: tx_count_next = tx_count;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_count_next = rx_count + CW'(1);
            2'b01:   rx_count_next = rx_count - CW'(1);
            default: rx_count_next = rx_count;
        endcase
    end

    // Read-data mux: RAM, RX head (0 when empty), status, or 0 for unmapped IO.
    always_comb begin
        rd_data = 8'h00;
        if (!is_io) begin
            rd_data = ram[ram_addr];
        end else if (sel_data) begin
            rd_data = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
        end else if (sel_stat) begin
            rd_data = {6'b0, (tx_count == DEPTH), rx_nonempty};
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr && !is_io) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // FIFO storage writes; stale entries are masked by the counts.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= mem_dout;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    // Registered read data; write cycles hold the previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din <= 8'h00;
        end else if (!mem_wr) begin
            mem_din <= rd_data;
        end
    end

    // TX pointers, count and near-full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            tx_count       <= tx_count_next;
            io_buffer_full <= (tx_count_next >= FULL_THRESH);
        end
    end

    // RX pointers, count and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_ready  <= 1'b1;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PW'(1);
            end
            rx_count <= rx_count_next;
            rx_ready <= (rx_count_next < DEPTH);
        end
    end

endmodule
